// File: rtl/slot_sched_pkg.sv
// Shared widths and helpers for the slot allocator and its round-robin pickers.
package slot_sched_pkg;

    localparam int DEF_NUM_SLOTS = 8;
    localparam int DEF_NUM_REQ   = 2;
    localparam int MAX_SLOTS     = 256;

    // Index width that never collapses to zero bits for a single-entry range.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int popcount(input logic [MAX_SLOTS-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < MAX_SLOTS; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set bit of mask at or after ptr, wrapping.
module rr_pick
    import slot_sched_pkg::*;
#(
    parameter int N = 4,
    parameter int W = clog2_min1(N)
) (
    input  logic [N-1:0] mask,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    int cand;

    // Walk from the farthest candidate back to ptr so the nearest hit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = int'(ptr) + i;
            if (cand >= N) cand = cand - N;
            if (mask[cand]) begin
                found = 1'b1;
                idx   = W'(cand);
            end
        end
    end

endmodule

// File: rtl/slot_alloc_sched.sv
// Free-slot allocator for the clock-crossing FIFO: round-robin requester and slot
// selection, drain-side releases, registered free mask/count and double-release flag.
module slot_alloc_sched
    import slot_sched_pkg::*;
#(
    parameter int NUM_SLOTS = DEF_NUM_SLOTS,
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic                               aclk,
    input  logic                               areset,
    input  logic [NUM_REQ-1:0]                 req,
    output logic [NUM_REQ-1:0]                 gnt,
    output logic [SLOT_W-1:0]                  gnt_slot,
    input  logic                               rel_valid,
    input  logic [SLOT_W-1:0]                  rel_slot,
    output logic [NUM_SLOTS-1:0]               free_mask,
    output logic [$clog2(NUM_SLOTS+1)-1:0]     free_count,
    output logic                               full_alloc,
    output logic                               err_double_release
);

    localparam int CNT_W = $clog2(NUM_SLOTS + 1);
    localparam int RP_W  = clog2_min1(NUM_REQ);

    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [SLOT_W-1:0]    gnt_slot_q, gnt_slot_d;
    logic [NUM_SLOTS-1:0] free_mask_q, free_mask_d;
    logic [CNT_W-1:0]     free_count_q, free_count_d;
    logic                 full_q, full_d;
    logic                 err_q, err_d;
    logic [RP_W-1:0]      rp_q, rp_d;
    logic [SLOT_W-1:0]    sp_q, sp_d;

    logic [NUM_REQ-1:0]   elig;
    logic                 req_found, slot_found, do_grant, rel_ok;
    logic [RP_W-1:0]      win;
    logic [SLOT_W-1:0]    slot;
    logic [MAX_SLOTS-1:0] mask_wide;

    // A requester that is seeing its grant this cycle cannot win again.
    assign elig = req & ~gnt_q;

    rr_pick #(.N(NUM_REQ), .W(RP_W)) u_req_pick (
        .mask  (elig),
        .ptr   (rp_q),
        .found (req_found),
        .idx   (win)
    );

    rr_pick #(.N(NUM_SLOTS), .W(SLOT_W)) u_slot_pick (
        .mask  (free_mask_q),
        .ptr   (sp_q),
        .found (slot_found),
        .idx   (slot)
    );

    always_comb begin
        do_grant     = req_found & slot_found;
        rel_ok       = rel_valid && (int'(rel_slot) < NUM_SLOTS) && !free_mask_q[rel_slot];
        free_mask_d  = free_mask_q;
        if (do_grant) free_mask_d[slot] = 1'b0;
        if (rel_ok)   free_mask_d[rel_slot] = 1'b1;
        mask_wide    = '0;
        mask_wide[NUM_SLOTS-1:0] = free_mask_d;
        free_count_d = CNT_W'(popcount(mask_wide));
        full_d       = (free_count_d == '0);
        err_d        = rel_valid & ~rel_ok;
        gnt_d        = '0;
        gnt_slot_d   = '0;
        rp_d         = rp_q;
        sp_d         = sp_q;
        if (do_grant) begin
            gnt_d[win] = 1'b1;
            gnt_slot_d = slot;
            rp_d       = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
            sp_d       = (int'(slot) == NUM_SLOTS - 1) ? '0 : slot + 1'b1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            gnt_q        <= '0;
            gnt_slot_q   <= '0;
            free_mask_q  <= '1;
            free_count_q <= CNT_W'(NUM_SLOTS);
            full_q       <= 1'b0;
            err_q        <= 1'b0;
            rp_q         <= '0;
            sp_q         <= '0;
        end else begin
            gnt_q        <= gnt_d;
            gnt_slot_q   <= gnt_slot_d;
            free_mask_q  <= free_mask_d;
            free_count_q <= free_count_d;
            full_q       <= full_d;
            err_q        <= err_d;
            rp_q         <= rp_d;
            sp_q         <= sp_d;
        end
    end

    assign gnt                = gnt_q;
    assign gnt_slot           = gnt_slot_q;
    assign free_mask          = free_mask_q;
    assign free_count         = free_count_q;
    assign full_alloc         = full_q;
    assign err_double_release = err_q;

endmodule

// File: tb/tb_slot_alloc_sched.sv
// Directed vector bench for slot_alloc_sched with four slots and two requesters.
module tb_slot_alloc_sched;

    localparam int NS = 4;
    localparam int NR = 2;

    logic          aclk = 1'b0;
    logic          areset;
    logic [NR-1:0] req;
    logic [NR-1:0] gnt;
    logic [1:0]    gnt_slot;
    logic          rel_valid;
    logic [1:0]    rel_slot;
    logic [NS-1:0] free_mask;
    logic [2:0]    free_count;
    logic          full_alloc;
    logic          err_double_release;

    slot_alloc_sched #(.NUM_SLOTS(NS), .NUM_REQ(NR)) dut (
        .aclk               (aclk),
        .areset             (areset),
        .req                (req),
        .gnt                (gnt),
        .gnt_slot           (gnt_slot),
        .rel_valid          (rel_valid),
        .rel_slot           (rel_slot),
        .free_mask          (free_mask),
        .free_count         (free_count),
        .full_alloc         (full_alloc),
        .err_double_release (err_double_release)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [1:0] req;
        logic       rv;
        logic [1:0] rs;
        logic [1:0] g;
        logic [1:0] gs;
        logic [3:0] m;
        logic [2:0] c;
        logic       f;
        logic       e;
    } vec_t;

    vec_t vecs [14];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic [1:0] rq, input logic rv, input logic [1:0] rs,
                                input logic [1:0] g, input logic [1:0] gs, input logic [3:0] m,
                                input logic [2:0] c, input logic f, input logic e);
        vec_t v;
        v.req = rq; v.rv = rv; v.rs = rs; v.g = g; v.gs = gs;
        v.m = m; v.c = c; v.f = f; v.e = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [1:0] g, input logic [1:0] gs,
                            input logic [3:0] m, input logic [2:0] c, input logic f, input logic e);
        chk({tag, ".gnt"}, 32'(gnt), 32'(g));
        if (g != 2'b00) chk({tag, ".gnt_slot"}, 32'(gnt_slot), 32'(gs));
        chk({tag, ".free_mask"}, 32'(free_mask), 32'(m));
        chk({tag, ".free_count"}, 32'(free_count), 32'(c));
        chk({tag, ".full_alloc"}, 32'(full_alloc), 32'(f));
        chk({tag, ".err_dbl"}, 32'(err_double_release), 32'(e));
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        //              req    rv    rs     gnt    slot   mask     cnt   full  err
        vecs[0]  = mk(2'b01, 1'b0, 2'd0, 2'b01, 2'd0, 4'b1110, 3'd3, 1'b0, 1'b0);
        vecs[1]  = mk(2'b10, 1'b0, 2'd0, 2'b10, 2'd1, 4'b1100, 3'd2, 1'b0, 1'b0);
        vecs[2]  = mk(2'b01, 1'b0, 2'd0, 2'b01, 2'd2, 4'b1000, 3'd1, 1'b0, 1'b0);
        vecs[3]  = mk(2'b10, 1'b0, 2'd0, 2'b10, 2'd3, 4'b0000, 3'd0, 1'b1, 1'b0);
        vecs[4]  = mk(2'b11, 1'b0, 2'd0, 2'b00, 2'd0, 4'b0000, 3'd0, 1'b1, 1'b0);
        vecs[5]  = mk(2'b11, 1'b0, 2'd0, 2'b00, 2'd0, 4'b0000, 3'd0, 1'b1, 1'b0);
        vecs[6]  = mk(2'b01, 1'b1, 2'd2, 2'b00, 2'd0, 4'b0100, 3'd1, 1'b0, 1'b0);
        vecs[7]  = mk(2'b01, 1'b0, 2'd0, 2'b01, 2'd2, 4'b0000, 3'd0, 1'b1, 1'b0);
        vecs[8]  = mk(2'b00, 1'b1, 2'd0, 2'b00, 2'd0, 4'b0001, 3'd1, 1'b0, 1'b0);
        vecs[9]  = mk(2'b00, 1'b1, 2'd3, 2'b00, 2'd0, 4'b1001, 3'd2, 1'b0, 1'b0);
        vecs[10] = mk(2'b10, 1'b1, 2'd1, 2'b10, 2'd3, 4'b0011, 3'd2, 1'b0, 1'b0);
        vecs[11] = mk(2'b00, 1'b1, 2'd1, 2'b00, 2'd0, 4'b0011, 3'd2, 1'b0, 1'b1);
        // rel_slot=5 truncates to slot 1 on a 2-bit port, which is free: same error pulse.
        vecs[12] = mk(2'b00, 1'b1, 2'(5),2'b00, 2'd0, 4'b0011, 3'd2, 1'b0, 1'b1);
        vecs[13] = mk(2'b00, 1'b0, 2'd0, 2'b00, 2'd0, 4'b0011, 3'd2, 1'b0, 1'b0);

        areset    = 1'b1;
        req       = '0;
        rel_valid = 1'b0;
        rel_slot  = '0;
        #12;
        chk_outs("reset", 2'b00, 2'd0, 4'b1111, 3'd4, 1'b0, 1'b0);
        areset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            req       = vecs[i].req;
            rel_valid = vecs[i].rv;
            rel_slot  = vecs[i].rs;
            step();
            chk_outs($sformatf("v%0d", i), vecs[i].g, vecs[i].gs, vecs[i].m,
                     vecs[i].c, vecs[i].f, vecs[i].e);
        end

        // Reset in the middle of a grant with three slots in use.
        areset = 1'b1;
        #1;
        chk_outs("pre_reset_clear", 2'b00, 2'd0, 4'b1111, 3'd4, 1'b0, 1'b0);
        #2;
        areset = 1'b0;
        req = 2'b01; step(); chk_outs("mr_a", 2'b01, 2'd0, 4'b1110, 3'd3, 1'b0, 1'b0);
        req = 2'b10; step(); chk_outs("mr_b", 2'b10, 2'd1, 4'b1100, 3'd2, 1'b0, 1'b0);
        req = 2'b01; step(); chk_outs("mr_c", 2'b01, 2'd2, 4'b1000, 3'd1, 1'b0, 1'b0);
        req = 2'b11;
        areset = 1'b1;
        #1;
        chk_outs("mid_reset", 2'b00, 2'd0, 4'b1111, 3'd4, 1'b0, 1'b0);
        #2;
        areset = 1'b0;
        step();
        chk_outs("post_reset", 2'b01, 2'd0, 4'b1110, 3'd3, 1'b0, 1'b0);
        req = 2'b10;
        step();
        chk_outs("post_reset2", 2'b10, 2'd1, 4'b1100, 3'd2, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/slot_alloc_sched.md
Name: slot_alloc_sched

Overview:
- Controller for the bank of per-slot free/used flags in the clock-crossing FIFO.
- Shares NUM_SLOTS buffer slots between NUM_REQ write-side requesters and hands out a free slot index on each grant.
- Accepts slot releases from the drain side and keeps a registered free mask and free count.
- Slot search and requester selection are both round-robin, so no requester and no slot starves.

Parameters:
- NUM_SLOTS, 8, number of buffer slots (≥2).
- NUM_REQ, 2, number of allocation requesters (≥1).
- SLOT_W, $clog2(NUM_SLOTS), slot index width (derived; do not override).

Ports:
- aclk  in  1  single clock for all logic.
- areset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester allocation request, level, held until granted.
- gnt  out  NUM_REQ  one-hot grant pulse, registered.
- gnt_slot  out  SLOT_W  slot index for the current grant; valid while any gnt bit is 1.
- rel_valid  in  1  release strobe.
- rel_slot  in  SLOT_W  slot being released.
- free_mask  out  NUM_SLOTS  bit i = 1 means slot i is free.
- free_count  out  $clog2(NUM_SLOTS+1)  population count of free_mask.
- full_alloc  out  1  no free slot (free_count == 0).
- err_double_release  out  1  one-cycle pulse: release of a slot that is already free.

Behaviour:
- Reset (async assert, sync-style deassert by the system):
  - free_mask = all 1s; free_count = NUM_SLOTS; full_alloc = 0.
  - gnt = 0; gnt_slot = 0; err_double_release = 0.
  - Requester pointer rp = 0; slot pointer sp = 0.
- Reset mid-operation discards all outstanding grants and releases. All slots return to free.
- Eligible requests: elig = req & ~gnt.
  - A requester holding req is never granted twice back-to-back.
  - A requester drops req in the cycle it sees gnt.
  - Maximum grant rate is one per requester every 2 cycles, and one total per cycle.
- Grant decision at edge k happens when elig ≠ 0 and the registered free_mask ≠ 0.
  - Requester: first set bit of elig at or after rp, wrapping.
  - Slot: first set bit of free_mask at or after sp, wrapping.
  - After edge k: gnt = one-hot(winner) and gnt_slot = slot for exactly one cycle; free_mask[slot] = 0.
  - Pointer update: rp = winner+1 mod NUM_REQ; sp = slot+1 mod NUM_SLOTS.
- Latency: req sampled high → gnt high 1 cycle later. With no eligible request or no free slot, gnt = 0 and the pointers hold.
- Release:
  - rel_valid at edge k sets free_mask[rel_slot] = 1 after edge k.
  - The released slot is allocatable from edge k+1 onward; allocation at edge k uses the pre-release mask.
  - Release of an already-free slot: mask unchanged and err_double_release = 1 for one cycle.
  - rel_slot ≥ NUM_SLOTS: treated as a double release (error pulse, no change).
- Simultaneous grant and release in the same cycle: both apply. They cannot target the same slot, since only used slots release and only free slots grant.
  - free_count = old − grant + release, saturating to 0..NUM_SLOTS.
- free_count and full_alloc are registered and consistent with free_mask in the same cycle.
- Wrap-around: pointers wrap modulo their range. Non-power-of-two NUM_SLOTS / NUM_REQ must work.

Decomposition:
- Package slot_sched_pkg:
  - function clog2_min1(n), returns at least 1;
  - function popcount;
  - localparam default widths.
- Sub-module rr_pick #(N):
  - inputs: mask[N], ptr;
  - outputs: found, idx;
  - combinational first-set-at-or-after-ptr with wrap;
  - instantiated twice: once for requesters, once for slots.

Test Plan (NUM_SLOTS=4, NUM_REQ=2):
- Reset, then req=2'b01 held until gnt → gnt=01 one cycle after req, gnt_slot=0; free_mask=4'b1110; free_count=3.
- req=2'b11 held continuously; each requester drops req after its gnt, then reasserts → grants alternate 01,10,01,10 with slots 0,1,2,3; then full_alloc=1 and gnt stays 0 while req remains high.
- From full, rel_valid with rel_slot=2 while req=01 → free_mask=0100 the cycle after the release; grant to slot 2 at the following edge (sp wrapped from 0 to 2).
- Grant and release on the same edge from free_count=2 (release one used slot, grant another) → free_count stays 2; free_mask reflects both.
- Release slot 1 while it is already free → err_double_release pulses 1 cycle; free_mask and free_count unchanged; rel_slot=5 gives the same response.
- areset pulsed while gnt=1 and 3 slots are used → gnt=0, free_mask=1111, free_count=4 immediately; the first grant after reset returns slot 0 to requester 0.
